aes_host_seq: RTL
=================

// Module: aes_host_seq
// PURPOSE
//  Initiator side of the AES core interface (clk, rst, mode, ld, kld, key, text_in, text_out, done).
//  Accepts 128-bit block requests on a valid/ready stream and sequences them into the core.
//  - Encrypt: a single ld pulse.
//  - Decrypt: a kld pulse, then a key-expansion wait, then ld.
//  Waits for done, captures text_out and returns it on a valid/ready response stream.
//  Sits between the system bus adapter and the AES core; one block in flight at a time.
// PARAMETERS
//  KEY_EXP_CYCLES  11   cycles from the aes_kld pulse until the inverse core accepts ld
//  TIMEOUT_CYCLES  64   max cycles in BUSY before abort (used only with AES_HOST_TIMEOUT_EN)
// PORTS
//  clk           in   1    single clock
//  rst           in   1    synchronous reset, active-high
//  req_valid     in   1    request present
//  req_ready     out  1    request accepted when req_valid && req_ready
//  req_mode      in   1    0 = encrypt, 1 = decrypt
//  req_key       in   128  cipher key
//  req_text      in   128  plaintext (encrypt) / ciphertext (decrypt)
//  rsp_valid     out  1    response present
//  rsp_ready     in   1    response consumed when rsp_valid && rsp_ready
//  rsp_text      out  128  result block
//  rsp_err       out  1    1 = aborted by timeout; rsp_text is 0
//  busy          out  1    state != IDLE
//  aes_mode      out  1    registered req_mode to the core
//  aes_ld        out  1    one-cycle load pulse to the core
//  aes_kld       out  1    one-cycle key-load pulse to the inverse core
//  aes_key       out  128  registered key, stable from accept until the response is consumed
//  aes_text_in   out  128  registered text, held stable over the same window as aes_key
//  aes_text_out  in   128  core result, sampled only in the aes_done cycle
//  aes_done      in   1    core completion pulse
// BEHAVIOUR
//  Reset values (apply on any cycle rst=1, including mid-operation):
//  - state=IDLE; all outputs 0 except req_ready=1 on the first cycle after reset.
//  - Key cache valid bit cleared; any in-flight block is dropped and no response is issued.
//  States: IDLE, KEXP, LOAD, BUSY, RESP.
//  IDLE:
//  - req_ready=1. On handshake, register mode, key and text.
//  - Encrypt -> LOAD.
//  - Decrypt with cache valid && req_key == cached key -> LOAD (no kld).
//  - Any other decrypt -> KEXP.
//  KEXP:
//  - aes_kld=1 in the first cycle only; a counter runs 0..KEY_EXP_CYCLES-1.
//  - At terminal count: cached key <= key, cache valid=1, go to LOAD.
//  LOAD: aes_ld=1 for exactly one cycle -> BUSY.
//  BUSY:
//  - On aes_done: rsp_text <= aes_text_out, rsp_err <= 0 -> RESP.
//  - aes_done seen in any other state is ignored.
//  RESP:
//  - rsp_valid=1; rsp_text/rsp_err held stable until rsp_ready.
//  - On handshake -> IDLE; req_ready rises the next cycle.
//  Timing:
//  - Encrypt: ld is asserted 1 cycle after accept; rsp_valid 1 cycle after done.
//  - Decrypt (cache miss): ld is asserted KEY_EXP_CYCLES+1 cycles after accept.
//  - req_ready=0 in all states except IDLE, so a new request can never collide with RESP.
// CONFIGURATION
//  AES_HOST_TIMEOUT_EN defined:
//  - A BUSY cycle counter starts at 0 on BUSY entry.
//  - If it reaches TIMEOUT_CYCLES without aes_done -> RESP with rsp_err=1, rsp_text=0, cache valid=0.
//  - aes_done arriving in the same cycle as the timeout wins: normal response, rsp_err=0.
//  AES_HOST_TIMEOUT_EN undefined: BUSY waits indefinitely; rsp_err is tied to 0.
// TESTING
//  1. Encrypt, key 000102030405060708090a0b0c0d0e0f, text 00112233445566778899aabbccddeeff
//     -> one aes_ld pulse, no aes_kld; rsp_text=69c4e0d86a7b0430d8cdb78070b4c55a, rsp_err=0.
//  2. Decrypt 69c4e0d86a7b0430d8cdb78070b4c55a with the same key
//     -> aes_kld pulse, aes_ld exactly 11 cycles later; rsp_text=00112233445566778899aabbccddeeff.
//  3. Second decrypt with the same key -> no aes_kld; aes_ld 1 cycle after accept.
//     Then a decrypt with a different key -> aes_kld is issued again.
//  4. Hold rsp_ready=0 for 5 cycles in RESP -> rsp_valid and rsp_text stable, req_ready=0 throughout.
//     Release -> IDLE, and req_ready=1 on the next cycle.
//  5. Assert rst for 1 cycle while in BUSY -> all outputs 0, next cycle req_ready=1.
//     A later aes_done produces no response; the next decrypt re-issues aes_kld.
//  6. (AES_HOST_TIMEOUT_EN) Never assert aes_done -> exactly 64 cycles after BUSY entry, rsp_valid=1 with rsp_err=1 and rsp_text=0.

Source files
------------

// File: rtl/aes_host_seq.sv
// aes_host_seq: initiator-side sequencer for a 128-bit AES core.
// Accepts one block request at a time, issues ld (encrypt) or kld + key-expansion wait + ld
// (decrypt), waits for done and returns the captured result on a valid/ready stream.
// The last expanded decrypt key is cached so repeated decrypts skip the kld/expansion step.
// Optional feature: define AES_HOST_TIMEOUT_EN to abort a BUSY wait after TIMEOUT_CYCLES.
module aes_host_seq #(
  parameter int unsigned KEY_EXP_CYCLES = 11,
  parameter int unsigned TIMEOUT_CYCLES = 64
) (
  input  logic         clk_i,
  input  logic         rst_i,
  input  logic         req_valid_i,
  output logic         req_ready_o,
  input  logic         req_mode_i,
  input  logic [127:0] req_key_i,
  input  logic [127:0] req_text_i,
  output logic         rsp_valid_o,
  input  logic         rsp_ready_i,
  output logic [127:0] rsp_text_o,
  output logic         rsp_err_o,
  output logic         busy_o,
  output logic         aes_mode_o,
  output logic         aes_ld_o,
  output logic         aes_kld_o,
  output logic [127:0] aes_key_o,
  output logic [127:0] aes_text_in_o,
  input  logic [127:0] aes_text_out_i,
  input  logic         aes_done_i
);

  localparam logic [2:0] StIdle = 3'd0;
  localparam logic [2:0] StKexp = 3'd1;
  localparam logic [2:0] StLoad = 3'd2;
  localparam logic [2:0] StBusy = 3'd3;
  localparam logic [2:0] StResp = 3'd4;

  // One counter serves both the key-expansion wait and the BUSY timeout.
  localparam logic [15:0] KexpLast = 16'(KEY_EXP_CYCLES - 1);

  logic [2:0]   state_q, state_d;
  logic [15:0]  cnt_q, cnt_d;
  logic         mode_q, mode_d;
  logic [127:0] key_q, key_d;
  logic [127:0] text_q, text_d;
  logic [127:0] rsp_text_q, rsp_text_d;
  logic [127:0] cache_key_q, cache_key_d;
  logic         cache_vld_q, cache_vld_d;
  logic         cache_hit;

`ifdef AES_HOST_TIMEOUT_EN
  localparam logic [15:0] ToLast = 16'(TIMEOUT_CYCLES - 1);
  logic         rsp_err_q, rsp_err_d;
`endif

  assign cache_hit = cache_vld_q && (req_key_i == cache_key_q);

  // Next-state logic: request capture, key expansion, load, completion wait, response hold.
  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    mode_d      = mode_q;
    key_d       = key_q;
    text_d      = text_q;
    rsp_text_d  = rsp_text_q;
    cache_key_d = cache_key_q;
    cache_vld_d = cache_vld_q;
`ifdef AES_HOST_TIMEOUT_EN
    rsp_err_d   = rsp_err_q;
`endif
    case (state_q)
      StIdle: begin
        if (req_valid_i) begin
          mode_d = req_mode_i;
          key_d  = req_key_i;
          text_d = req_text_i;
          cnt_d  = '0;
          // Encrypt needs no key schedule; a decrypt with the cached key is already expanded.
          if (!req_mode_i || cache_hit) begin
            state_d = StLoad;
          end else begin
            state_d = StKexp;
          end
        end
      end
      StKexp: begin
        if (cnt_q == KexpLast) begin
          cache_key_d = key_q;
          cache_vld_d = 1'b1;
          cnt_d       = '0;
          state_d     = StLoad;
        end else begin
          cnt_d = cnt_q + 16'd1;
        end
      end
      StLoad: begin
        cnt_d   = '0;
        state_d = StBusy;
      end
      StBusy: begin
        // A done in the timeout cycle still counts as a normal completion.
        if (aes_done_i) begin
          rsp_text_d = aes_text_out_i;
`ifdef AES_HOST_TIMEOUT_EN
          rsp_err_d  = 1'b0;
`endif
          state_d    = StResp;
        end
`ifdef AES_HOST_TIMEOUT_EN
        else if (cnt_q == ToLast) begin
          rsp_text_d  = '0;
          rsp_err_d   = 1'b1;
          // The core state is unknown after an abort, so force a fresh key expansion.
          cache_vld_d = 1'b0;
          state_d     = StResp;
        end else begin
          cnt_d = cnt_q + 16'd1;
        end
`endif
      end
      StResp: begin
        if (rsp_ready_i) begin
          state_d = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  // State and datapath registers with synchronous reset.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q     <= StIdle;
      cnt_q       <= '0;
      mode_q      <= 1'b0;
      key_q       <= '0;
      text_q      <= '0;
      rsp_text_q  <= '0;
      cache_key_q <= '0;
      cache_vld_q <= 1'b0;
`ifdef AES_HOST_TIMEOUT_EN
      rsp_err_q   <= 1'b0;
`endif
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      mode_q      <= mode_d;
      key_q       <= key_d;
      text_q      <= text_d;
      rsp_text_q  <= rsp_text_d;
      cache_key_q <= cache_key_d;
      cache_vld_q <= cache_vld_d;
`ifdef AES_HOST_TIMEOUT_EN
      rsp_err_q   <= rsp_err_d;
`endif
    end
  end

  // Output decode from the registered state.
  always_comb begin
    req_ready_o   = (state_q == StIdle);
    rsp_valid_o   = (state_q == StResp);
    busy_o        = (state_q != StIdle);
    aes_ld_o      = (state_q == StLoad);
    aes_kld_o     = (state_q == StKexp) && (cnt_q == '0);
    aes_mode_o    = mode_q;
    aes_key_o     = key_q;
    aes_text_in_o = text_q;
    rsp_text_o    = rsp_text_q;
`ifdef AES_HOST_TIMEOUT_EN
    rsp_err_o     = rsp_err_q;
`else
    rsp_err_o     = 1'b0;
`endif
  end

endmodule
